uart_rx_deframer: RTL



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_sync_vote.sv | 28 ++
 rtl/uart_rx_deframer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, divisor defaults and LSR bit layout.
package uart_pkg;

    localparam int unsigned PERIOD_W    = 16;
    localparam int unsigned DEFAULT_DIV = 2604;
    localparam int unsigned MIN_PERIOD  = 4;

    // LSR bit positions seen by software through the MMIO wrapper
    localparam int unsigned LSR_RX_READY  = 0;
    localparam int unsigned LSR_OVERRUN   = 1;
    localparam int unsigned LSR_FRAME_ERR = 3;
    localparam int unsigned LSR_TX_AVAI   = 5;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_e;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_sync_vote.sv
// Two-flop synchroniser followed by a 3-sample history and majority vote.
// Reusable for any asynchronous, idle-high input pin.
module uart_rx_sync_vote
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic pin,
    output logic level_c
);

    logic [1:0] sync;
    logic [2:0] hist;

    // Flops reset to the idle-high level so reset never looks like a start edge
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync <= 2'b11;
            hist <= 3'b111;
        end else begin
            sync <= {sync[0], pin};
            hist <= {hist[1:0], sync[1]};
        end
    end

    assign level_c = majority3(hist);

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 receive deframer: filtered rxd, programmable bit period, single-byte holding
// register with sticky frame-error and overrun status for the LSR.
module uart_rx_deframer #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned MIN_PERIOD = uart_pkg::MIN_PERIOD
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [uart_pkg::PERIOD_W-1:0] period,
    input  logic                          rxd,
    input  logic                          rx_clear,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun
);

    import uart_pkg::*;

    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic                 bit_val;
    rx_state_e            state;
    logic [PERIOD_W-1:0]  cnt;
    logic [PERIOD_W-1:0]  p_q;
    logic [PERIOD_W-1:0]  p_eff;
    logic [PERIOD_W-1:0]  half_m1;
    logic [PERIOD_W-1:0]  p_m1;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 done;

    uart_rx_sync_vote u_sync_vote (
        .clk     (clk),
        .rstn    (rstn),
        .pin     (rxd),
        .level_c (bit_val)
    );

    // Period floor keeps half-bit and full-bit compares meaningful
    assign p_eff   = (period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : period;
    assign half_m1 = (p_q >> 1) - PERIOD_W'(1);
    assign p_m1    = p_q - PERIOD_W'(1);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= RX_IDLE;
            cnt       <= '0;
            p_q       <= PERIOD_W'(MIN_PERIOD);
            idx       <= '0;
            shreg     <= '0;
            done      <= 1'b0;
            rx_data   <= '0;
            rx_ready  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done <= 1'b0;

            case (state)
                RX_IDLE: begin
                    if (!bit_val) begin
                        state <= RX_START;
                        cnt   <= '0;
                        p_q   <= p_eff;
                    end
                end
                // Mid-start-bit recheck rejects short glitches without touching status
                RX_START: begin
                    if (cnt == half_m1) begin
                        cnt <= '0;
                        if (!bit_val) begin
                            state <= RX_DATA;
                            idx   <= '0;
                        end else begin
                            state <= RX_IDLE;
                        end
                    end else begin
                        cnt <= cnt + PERIOD_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == p_m1) begin
                        cnt   <= '0;
                        shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                        idx   <= idx + IDX_W'(1);
                        if (idx == IDX_W'(DATA_BITS - 1)) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        cnt <= cnt + PERIOD_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == p_m1) begin
                        cnt <= '0;
                        if (bit_val) begin
                            state <= RX_IDLE;
                            done  <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= RX_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + PERIOD_W'(1);
                    end
                end
                // A held-low line (break) must return high before the next start
                RX_WAIT_HIGH: begin
                    if (bit_val) begin
                        state <= RX_IDLE;
                    end
                end
                default: begin
                    state <= RX_IDLE;
                    cnt   <= '0;
                end
            endcase

            // Holding register: a clear coinciding with completion counts as a fresh load
            if (done) begin
                if (!rx_ready || rx_clear) begin
                    rx_data   <= shreg;
                    rx_ready  <= 1'b1;
                    frame_err <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_clear && rx_ready) begin
                rx_ready <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

endmodule
